// File: rtl/btn_pkg.sv
// Shared definitions for the button debounce array: channel FSM encoding and
// the counter-width helper used to size the tick counters.
package btn_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ARM_P = 2'd1,
      HELD  = 2'd2,
      ARM_R = 2'd3
   } btn_state_e;

   // Bits needed to hold every value 0..max_val, so a load of max_val never truncates.
   function automatic int cnt_width(input int max_val);
      return (max_val < 1) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/btn_debounce_ch.sv
// One button channel: 2-flop synchroniser, tick-paced debounce FSM, hold counter
// and registered pulses. Optional auto-repeat is enabled by BTN_AUTO_REPEAT_EN.
module btn_debounce_ch
   import btn_pkg::*;
#(
   parameter int DEBOUNCE_TICKS = 10,
   parameter int LONG_TICKS     = 100,
   parameter int REPEAT_TICKS   = 20
) (
   input  logic clk,
   input  logic reset,
   input  logic tick,
   input  logic noise_btn,
   output logic clean_btn,
   output logic press_pulse,
   output logic release_pulse,
   output logic long_pulse,
   output logic repeat_pulse
);

   if (DEBOUNCE_TICKS < 1 || LONG_TICKS < 1 || REPEAT_TICKS < 1) begin : g_bad_param
      $error("btn_debounce_ch: tick parameters must all be >= 1");
   end

   localparam int CW = cnt_width(DEBOUNCE_TICKS);
   localparam int HW = cnt_width(LONG_TICKS);

   localparam logic [CW-1:0] CNT_LOAD = CW'(DEBOUNCE_TICKS);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_TICKS);
   localparam logic [HW-1:0] HOLD_ONE = HW'(1);

   logic [1:0]    sync_q;
   logic          s;
   btn_state_e    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [HW-1:0] hold_q, hold_d, hold_inc;
   logic          hold_adv;
   logic          press_q, press_d;
   logic          release_q, release_d;
   logic          long_q, long_d;

   assign s = sync_q[1];

   // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync_q    <= '0;
         state_q   <= IDLE;
         cnt_q     <= '0;
         hold_q    <= '0;
         press_q   <= 1'b0;
         release_q <= 1'b0;
         long_q    <= 1'b0;
      end else begin
         sync_q    <= {sync_q[0], noise_btn};
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         hold_q    <= hold_d;
         press_q   <= press_d;
         release_q <= release_d;
         long_q    <= long_d;
      end
   end

   // NOTE: every combinational output gets a default first so no path infers a latch.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      hold_d    = hold_q;
      hold_inc  = hold_q + HOLD_ONE;
      hold_adv  = 1'b0;
      press_d   = 1'b0;
      release_d = 1'b0;
      long_d    = 1'b0;

      // A change on s wins over a coincident tick; that tick is simply not counted.
      unique case (state_q)
         IDLE: begin
            if (s) begin
               state_d = ARM_P;
               cnt_d   = CNT_LOAD;
            end
         end
         ARM_P: begin
            if (!s) begin
               state_d = IDLE;
            end else if (tick) begin
               if (cnt_q == CNT_ONE) begin
                  state_d = HELD;
                  press_d = 1'b1;
                  hold_d  = '0;
               end else begin
                  cnt_d = cnt_q - CNT_ONE;
               end
            end
         end
         HELD: begin
            if (!s) begin
               state_d = ARM_R;
               cnt_d   = CNT_LOAD;
            end else if (tick) begin
               hold_adv = 1'b1;
            end
         end
         ARM_R: begin
            if (s) begin
               state_d = HELD;
            end else if (tick) begin
               if (cnt_q == CNT_ONE) begin
                  state_d   = IDLE;
                  release_d = 1'b1;
                  hold_d    = '0;
               end else begin
                  cnt_d    = cnt_q - CNT_ONE;
                  hold_adv = 1'b1;
               end
            end
         end
      endcase

      // Saturating hold: long fires only on the tick that reaches the limit.
      if (hold_adv && (hold_q != HOLD_MAX)) begin
         hold_d = hold_inc;
         long_d = (hold_inc == HOLD_MAX);
      end
   end

   assign clean_btn     = (state_q == HELD) || (state_q == ARM_R);
   assign press_pulse   = press_q;
   assign release_pulse = release_q;
   assign long_pulse    = long_q;

`ifdef BTN_AUTO_REPEAT_EN
   localparam int RW = cnt_width(REPEAT_TICKS);

   localparam logic [RW-1:0] REP_LOAD = RW'(REPEAT_TICKS);
   localparam logic [RW-1:0] REP_ONE  = RW'(1);

   logic [RW-1:0] rep_q, rep_d;
   logic          repeat_q, repeat_d;

   // rep==0 means disarmed; it arms on long_pulse and paces off the same ticks as hold.
   always_comb begin
      rep_d    = rep_q;
      repeat_d = 1'b0;
      if (state_d == IDLE) begin
         rep_d = '0;
      end else if (long_d) begin
         rep_d = REP_LOAD;
      end else if (hold_adv && (rep_q != '0)) begin
         if (rep_q == REP_ONE) begin
            repeat_d = 1'b1;
            rep_d    = REP_LOAD;
         end else begin
            rep_d = rep_q - REP_ONE;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rep_q    <= '0;
         repeat_q <= 1'b0;
      end else begin
         rep_q    <= rep_d;
         repeat_q <= repeat_d;
      end
   end

   assign repeat_pulse = repeat_q;
`else
   assign repeat_pulse = 1'b0;
`endif

endmodule

// File: rtl/btn_debounce_array.sv
// N_BTN independent debounce channels sharing one tick time base.
// Auto-repeat pulses exist only when BTN_AUTO_REPEAT_EN is defined.
module btn_debounce_array
   import btn_pkg::*;
#(
   parameter int N_BTN          = 5,
   parameter int DEBOUNCE_TICKS = 10,
   parameter int LONG_TICKS     = 100,
   parameter int REPEAT_TICKS   = 20
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             tick,
   input  logic [N_BTN-1:0] noise_btn,
   output logic [N_BTN-1:0] clean_btn,
   output logic [N_BTN-1:0] press_pulse,
   output logic [N_BTN-1:0] release_pulse,
   output logic [N_BTN-1:0] long_pulse,
   output logic [N_BTN-1:0] repeat_pulse
);

   if (N_BTN < 1) begin : g_bad_n_btn
      $error("btn_debounce_array: N_BTN must be >= 1");
   end

   for (genvar i = 0; i < N_BTN; i++) begin : g_ch
      btn_debounce_ch #(
         .DEBOUNCE_TICKS (DEBOUNCE_TICKS),
         .LONG_TICKS     (LONG_TICKS),
         .REPEAT_TICKS   (REPEAT_TICKS)
      ) u_ch (
         .clk           (clk),
         .reset         (reset),
         .tick          (tick),
         .noise_btn     (noise_btn[i]),
         .clean_btn     (clean_btn[i]),
         .press_pulse   (press_pulse[i]),
         .release_pulse (release_pulse[i]),
         .long_pulse    (long_pulse[i]),
         .repeat_pulse  (repeat_pulse[i])
      );
   end

endmodule

// File: tb/tb_btn_debounce_array.sv
// Directed bench for btn_debounce_array: tick every 4 clk (or tied high), pulses
// logged by a negedge monitor and compared against hand-computed tick numbers.
module tb_btn_debounce_array;

   localparam int N   = 5;
   localparam int DEB = 10;
   localparam int LNG = 100;
   localparam int REP = 20;

   logic         clk;
   logic         reset;
   logic         tick;
   logic [N-1:0] noise_btn;
   logic [N-1:0] clean_btn;
   logic [N-1:0] press_pulse;
   logic [N-1:0] release_pulse;
   logic [N-1:0] long_pulse;
   logic [N-1:0] repeat_pulse;

   btn_debounce_array #(
      .N_BTN          (N),
      .DEBOUNCE_TICKS (DEB),
      .LONG_TICKS     (LNG),
      .REPEAT_TICKS   (REP)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .tick          (tick),
      .noise_btn     (noise_btn),
      .clean_btn     (clean_btn),
      .press_pulse   (press_pulse),
      .release_pulse (release_pulse),
      .long_pulse    (long_pulse),
      .repeat_pulse  (repeat_pulse)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   int tick_no = 0;
   int cyc     = 0;
   logic clr_mon = 1'b0;

   int press_cnt[N];
   int release_cnt[N];
   int long_cnt[N];
   int rep_cnt[N];
   int press_at[N];
   int release_at[N];
   int long_at[N];
   int press_cyc[N];
   int release_cyc[N];
   int rep_log[$];

   // Pulse counts are cycles-high, so a stretched pulse shows up as a count above 1.
   always @(negedge clk) begin
      cyc = cyc + 1;
      if (clr_mon) begin
         for (int i = 0; i < N; i++) begin
            press_cnt[i] = 0; release_cnt[i] = 0; long_cnt[i] = 0; rep_cnt[i] = 0;
            press_at[i] = -1; release_at[i] = -1; long_at[i] = -1;
            press_cyc[i] = -1; release_cyc[i] = -1;
         end
         rep_log.delete();
      end else begin
         for (int i = 0; i < N; i++) begin
            if (press_pulse[i] === 1'b1) begin
               press_cnt[i]++; press_at[i] = tick_no; press_cyc[i] = cyc;
            end
            if (release_pulse[i] === 1'b1) begin
               release_cnt[i]++; release_at[i] = tick_no; release_cyc[i] = cyc;
            end
            if (long_pulse[i] === 1'b1) begin
               long_cnt[i]++; long_at[i] = tick_no;
            end
            if (repeat_pulse[i] === 1'b1) begin
               rep_cnt[i]++; rep_log.push_back(tick_no);
            end
         end
      end
   end

   task automatic check(input string tag, input int got, input int exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic tick_period();
      tick_no++;
      tick = 1'b1;
      step();
      tick = 1'b0;
      step();
      step();
      step();
   endtask

   task automatic ticks(input int n);
      for (int k = 0; k < n; k++) tick_period();
   endtask

   task automatic clear_mon();
      clr_mon = 1'b1;
      step();
      clr_mon = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int exp_t;
      int c_t;
      int t0;
      int sum;

      reset     = 1'b1;
      tick      = 1'b0;
      noise_btn = '0;
      repeat (3) step();
      check("rst_clean",   int'(clean_btn),     0);
      check("rst_press",   int'(press_pulse),   0);
      check("rst_release", int'(release_pulse), 0);
      check("rst_long",    int'(long_pulse),    0);
      check("rst_repeat",  int'(repeat_pulse),  0);
      reset = 1'b0;
      clear_mon();

      // Idle after reset: nothing at all may fire.
      ticks(20);
      sum = 0;
      for (int i = 0; i < N; i++) sum += press_cnt[i] + release_cnt[i] + long_cnt[i] + rep_cnt[i];
      check("idle_pulses", sum, 0);
      check("idle_clean", int'(clean_btn), 0);

      // Clean press on ch0: the set-period tick is uncounted, then DEB counted ticks.
      clear_mon();
      noise_btn[0] = 1'b1;
      exp_t = tick_no + 1 + DEB;
      ticks(DEB);
      check("press_early_clean", int'(clean_btn[0]), 0);
      ticks(1);
      check("press_tick", press_at[0], exp_t);
      check("press_width", press_cnt[0], 1);
      check("press_clean", int'(clean_btn[0]), 1);
      c_t = exp_t;

      // Glitch while HELD: 50 ticks held, 5 ticks low, then held until hold = LNG.
      ticks(50);
      noise_btn[0] = 1'b0;
      ticks(5);
      check("glitch_clean", int'(clean_btn[0]), 1);
      noise_btn[0] = 1'b1;
      ticks(45);
      check("glitch_long_tick", long_at[0], c_t + LNG);
      check("glitch_long_cnt", long_cnt[0], 1);
      check("glitch_press_cnt", press_cnt[0], 1);
      check("glitch_release_cnt", release_cnt[0], 0);

      // Release right after the long pulse: symmetric debounce, no repeat.
      noise_btn[0] = 1'b0;
      exp_t = tick_no + 1 + DEB;
      ticks(DEB + 1);
      check("release_tick", release_at[0], exp_t);
      check("release_width", release_cnt[0], 1);
      check("release_clean", int'(clean_btn[0]), 0);
      check("release_no_repeat", rep_cnt[0], 0);

      // Bounce on ch1: toggle every 3 ticks for 30 ticks, then stay high.
      clear_mon();
      for (int seg = 0; seg < 10; seg++) begin
         noise_btn[1] = ((seg % 2) == 0);
         ticks(3);
      end
      check("bounce_quiet", press_cnt[1] + release_cnt[1], 0);
      noise_btn[1] = 1'b1;
      exp_t = tick_no + 1 + DEB;
      ticks(DEB + 1);
      check("bounce_press_tick", press_at[1], exp_t);
      check("bounce_press_cnt", press_cnt[1], 1);
      noise_btn[1] = 1'b0;
      ticks(DEB + 1);
      check("bounce_release_cnt", release_cnt[1], 1);

      // Channels 0 and 3 pressed in the same cycle.
      clear_mon();
      noise_btn = 5'b01001;
      exp_t = tick_no + 1 + DEB;
      ticks(DEB + 1);
      check("multi_press0", press_at[0], exp_t);
      check("multi_press3", press_at[3], exp_t);
      check("multi_same_cycle", press_cyc[3], press_cyc[0]);
      check("multi_others", press_cnt[1] + press_cnt[2] + press_cnt[4], 0);
      check("multi_clean", int'(clean_btn), 9);
      noise_btn = '0;
      exp_t = tick_no + 1 + DEB;
      ticks(DEB + 1);
      check("multi_release0", release_at[0], exp_t);
      check("multi_release3", release_at[3], exp_t);

      // Long hold on ch2 for 200 ticks of hold.
      clear_mon();
      noise_btn[2] = 1'b1;
      c_t = tick_no + 1 + DEB;
      ticks(DEB + 1);
      ticks(200);
      check("hold_long_tick", long_at[2], c_t + LNG);
      check("hold_long_cnt", long_cnt[2], 1);
`ifdef BTN_AUTO_REPEAT_EN
      check("hold_rep_cnt", rep_cnt[2], 5);
      for (int k = 0; k < 5; k++)
         check($sformatf("hold_rep_tick%0d", k), (k < rep_log.size()) ? rep_log[k] : -1,
               c_t + LNG + REP * (k + 1));
`else
      check("hold_rep_cnt", rep_cnt[2], 0);
`endif
      sum = rep_cnt[2];
      noise_btn[2] = 1'b0;
      ticks(DEB + 1);
      ticks(30);
      check("hold_release_cnt", release_cnt[2], 1);
      check("hold_rep_after_release", rep_cnt[2], sum);

      // Tick tied high on ch1: debounce takes DEB clk after ARM entry, pulses stay 1 clk.
      clear_mon();
      tick = 1'b1;
      noise_btn[1] = 1'b1;
      t0 = cyc;
      repeat (16) step();
      check("fast_press_cyc", press_cyc[1], t0 + 3 + DEB + 1);
      check("fast_press_width", press_cnt[1], 1);
      noise_btn[1] = 1'b0;
      t0 = cyc;
      repeat (16) step();
      check("fast_release_cyc", release_cyc[1], t0 + 3 + DEB + 1);
      check("fast_release_width", release_cnt[1], 1);
      check("fast_no_long", long_cnt[1], 0);
      tick = 1'b0;

      // Reset while ch4 is HELD and still pressed.
      clear_mon();
      noise_btn[4] = 1'b1;
      ticks(DEB + 1 + 5);
      check("mid_held_clean", int'(clean_btn[4]), 1);
      reset = 1'b1;
      step();
      check("mid_rst_clean", int'(clean_btn), 0);
      reset = 1'b0;
      exp_t = tick_no + 1 + DEB;
      ticks(DEB);
      check("mid_redebounce_early", int'(clean_btn[4]), 0);
      ticks(1);
      check("mid_redebounce_tick", press_at[4], exp_t);
      check("mid_press_cnt", press_cnt[4], 2);
      check("mid_no_release", release_cnt[4], 0);
      noise_btn[4] = 1'b0;
      ticks(DEB + 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
